// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS core types and constants
package mips_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_t;
  localparam logic [31:0] MIPS_NOP = 32'h0;
endpackage

// File: rtl/imem_addr_check.sv
// imem_addr_check: word-aligned, in-range byte address check and word index
module imem_addr_check #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic [WIDTH-1:0]  addr,
  output logic              valid,
  output logic [ADDR_W-1:0] index
);
  localparam logic [WIDTH-3:0] LIMIT = (WIDTH-2)'(DEPTH);
  assign valid = (addr[1:0] == 2'b00) && (addr[WIDTH-1:2] < LIMIT);
  assign index = addr[ADDR_W+1:2];
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: instruction-memory port shared by CPU fetch and program loader
module imem_arbiter
  import mips_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [WIDTH-1:0]  fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [WIDTH-1:0]  fetch_rdata,
  output logic              fetch_err,
  input  logic              load_req,
  input  logic [WIDTH-1:0]  load_addr,
  input  logic [WIDTH-1:0]  load_wdata,
  output logic              load_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  state_t state, state_nx;
  logic [CW-1:0] wait_cnt, wait_nx;
  logic inv;
  logic fetch_ok, load_ok, wait_max;
  logic [ADDR_W-1:0] fetch_idx, load_idx;
  imem_addr_check #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fetch_chk (
    .addr(fetch_addr), .valid(fetch_ok), .index(fetch_idx)
  );
  imem_addr_check #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_load_chk (
    .addr(load_addr), .valid(load_ok), .index(load_idx)
  );
  // grants are gated by rst_n so nothing is granted while reset is held
  assign wait_max  = wait_cnt == CW'(MAX_WAIT);
  assign fetch_gnt = rst_n & fetch_req & (~load_req | wait_max);
  assign load_gnt  = rst_n & load_req & ~fetch_gnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      inv      <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      inv      <= fetch_gnt & ~fetch_ok;
    end
  always_comb begin
    state_nx = fetch_gnt ? FETCH : load_gnt ? LOAD : IDLE;
    wait_nx  = (fetch_req & ~fetch_gnt) ? (wait_max ? wait_cnt : wait_cnt + 1'b1) : '0;
  end
  always_comb begin
    fetch_rvalid = state == FETCH;
    fetch_err    = fetch_rvalid & inv;
    fetch_rdata  = (fetch_rvalid & ~inv) ? mem_rdata : WIDTH'(MIPS_NOP);
    mem_we       = load_gnt & load_ok;
    mem_en       = (fetch_gnt & fetch_ok) | mem_we;
    mem_addr     = (fetch_gnt & fetch_ok) ? fetch_idx : mem_we ? load_idx : '0;
    mem_wdata    = mem_we ? load_wdata : '0;
  end
endmodule
